// File: rtl/core_pkg.sv
// Shared core types and constants for the fetch stage.
package core_pkg;

  localparam int unsigned INST_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;
  localparam logic [31:0] NOP_INST         = 32'h0340_0000;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
    logic              adef;
  } fetch_entry_t;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Shift-register skid FIFO; entry 0 is the head, so the outputs come straight from flops.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  fetch_entry_t  entry_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] cnt_o,
  output logic          valid_o,
  output fetch_entry_t  head_o
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d, wr_idx;
  logic          valid_q, valid_d, pop_eff;

  assign pop_eff = pop_i & valid_q;
  // A popping push lands one slot lower because the contents shift down.
  assign wr_idx  = cnt_q - CW'(pop_eff);

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      if (pop_eff) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) mem_d[i] = mem_q[i+1];
      end
      if (push_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (CW'(i) == wr_idx) mem_d[i] = entry_i;
        end
      end
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_eff);
    end
    valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign valid_o = valid_q;
  assign head_o  = mem_q[0];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push_i && !flush_i) |-> (cnt_q < CW'(DEPTH)));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives the 1-cycle instruction SRAM,
// buffers responses in a skid FIFO and restarts on EX redirects.
module if_fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_adef
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fpc_q, fpc_d, req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d, adef_pend_q, adef_pend_d;
  logic          en_raw, push, pop;
  logic [CW-1:0] cnt;
  logic [CW:0]   occ;
  fetch_entry_t  push_entry, head;

  assign pop = out_valid & ~stall;
  assign occ = (CW+1)'(cnt) + (CW+1)'(inflight_q) - (CW+1)'(pop);

  always_comb begin
    state_d        = state_q;
    fpc_d          = fpc_q;
    req_pc_d       = req_pc_q;
    inflight_d     = 1'b0;
    adef_pend_d    = 1'b0;
    en_raw         = 1'b0;
    inst_sram_addr = fpc_q;
    push           = 1'b0;
    push_entry     = '{pc: req_pc_q, inst: inst_sram_rdata, adef: 1'b0};
    if (redirect_valid) begin
      if (redirect_pc[1:0] == 2'b00) begin
        en_raw         = 1'b1;
        inst_sram_addr = redirect_pc;
        fpc_d          = redirect_pc + 32'd4;
        req_pc_d       = redirect_pc;
        inflight_d     = 1'b1;
        state_d        = FS_RUN;
      end else begin
        // req_pc carries the faulting PC into the deferred marker push.
        req_pc_d    = redirect_pc;
        adef_pend_d = 1'b1;
        state_d     = FS_HALT;
      end
    end else begin
      if (adef_pend_q) begin
        push       = 1'b1;
        push_entry = '{pc: req_pc_q, inst: '0, adef: 1'b1};
      end else if (inflight_q) begin
        push = 1'b1;
      end
      if (state_q == FS_RUN && occ < (CW+1)'(DEPTH)) begin
        en_raw     = 1'b1;
        fpc_d      = fpc_q + 32'd4;
        req_pc_d   = fpc_q;
        inflight_d = 1'b1;
      end
    end
  end

  assign inst_sram_en = en_raw & resetn;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= FS_RUN;
      fpc_q       <= RESET_PC;
      req_pc_q    <= '0;
      inflight_q  <= 1'b0;
      adef_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      req_pc_q    <= req_pc_d;
      inflight_q  <= inflight_d;
      adef_pend_q <= adef_pend_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .cnt_o   (cnt),
    .valid_o (out_valid),
    .head_o  (head)
  );

  assign out_pc   = head.pc;
  assign out_inst = head.inst;
  assign out_adef = head.adef;

endmodule
